// File: rtl/cdp_rdma_rdreq_sched.sv
// cdp_rdma_rdreq_sched
// Two-requester DMA read-request scheduler for the CDP read DMA.
//  - Round-robin arbitration gated by latency-FIFO credits (atoms).
//  - One-entry registered output stage (grant -> valid latency 1).
//  - IDLE/RUN/DRAIN layer FSM. done pulses when the drain completes.
// Optional feature: define CDP_RDMA_SCHED_PERF_EN to build the stall_cnt
// performance counter. Without it stall_cnt is a constant 0.
module cdp_rdma_rdreq_sched #(
  parameter int CDT_DEPTH = 64,
  parameter int CNT_W     = 7
) (
  input  logic             nvdla_core_clk,
  input  logic             nvdla_core_rst,
  input  logic             op_en,
  input  logic             req0_valid,
  output logic             req0_ready,
  input  logic [78:0]      req0_pd,
  input  logic             req1_valid,
  output logic             req1_ready,
  input  logic [78:0]      req1_pd,
  output logic             dma_rd_req_valid,
  input  logic             dma_rd_req_ready,
  output logic [78:0]      dma_rd_req_pd,
  output logic             dma_rd_req_src,
  input  logic             cdt_lat_fifo_pop,
  output logic [CNT_W-1:0] credit_cnt,
  output logic             done,
  output logic             credit_ovf,
  output logic [31:0]      stall_cnt
);

  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

  localparam logic [CNT_W-1:0] CDT_FULL = CNT_W'(CDT_DEPTH);
  localparam logic [16:0]      CDT_FULL17 = 17'(CDT_DEPTH);

  state_t      state;
  logic        rr_pref;      // requester that wins the next tie
  logic [15:0] credit16;
  logic [15:0] cost0, cost1, gnt_cost;
  logic        elig0, elig1;
  logic        can_grant, gnt0, gnt1, grant;
  logic [16:0] credit_sum;
  logic        credit_sat;
  logic [CNT_W-1:0] credit_nxt;
  logic        out_valid_nxt;
  logic        drain_fin;

  // Atom cost of each request is size+1; compare at 16 bits so a large
  // size field can never wrap into an apparently cheap request.
  assign credit16 = 16'(credit_cnt);
  assign cost0    = {1'b0, req0_pd[78:64]} + 16'd1;
  assign cost1    = {1'b0, req1_pd[78:64]} + 16'd1;
  assign elig0    = req0_valid && (cost0 <= credit16);
  assign elig1    = req1_valid && (cost1 <= credit16);

  // Grant only while running and the output stage is free this cycle.
  assign can_grant = !nvdla_core_rst && (state == RUN) &&
                     (!dma_rd_req_valid || dma_rd_req_ready);
  assign gnt0  = can_grant && elig0 && (!elig1 || !rr_pref);
  assign gnt1  = can_grant && elig1 && (!elig0 ||  rr_pref);
  assign grant = gnt0 || gnt1;

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;

  // Net credit change for the cycle; a pop into a full pool saturates.
  always_comb begin
    gnt_cost   = 16'd0;
    if (gnt0) gnt_cost = cost0;
    if (gnt1) gnt_cost = cost1;
    credit_sum = 17'(credit_cnt) + 17'(cdt_lat_fifo_pop) - 17'(gnt_cost);
    credit_sat = (credit_sum > CDT_FULL17);
    credit_nxt = credit_sat ? CDT_FULL : credit_sum[CNT_W-1:0];
  end

  // Drain completes on the edge where the output stage empties and the
  // credit pool becomes full; looking ahead lets done be a plain flop.
  assign out_valid_nxt = grant || (dma_rd_req_valid && !dma_rd_req_ready);
  assign drain_fin     = (state == DRAIN) && !out_valid_nxt &&
                         (credit_nxt == CDT_FULL);

  // Output stage: load on grant, retire on downstream accept, hold otherwise.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      dma_rd_req_valid <= 1'b0;
      dma_rd_req_pd    <= '0;
      dma_rd_req_src   <= 1'b0;
    end else begin
      dma_rd_req_valid <= out_valid_nxt;
      if (grant) begin
        dma_rd_req_pd  <= gnt1 ? req1_pd : req0_pd;
        dma_rd_req_src <= gnt1;
      end
    end
  end

  // Credit pool, sticky overflow flag and round-robin pointer.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      credit_cnt <= CDT_FULL;
      credit_ovf <= 1'b0;
      rr_pref    <= 1'b0;
    end else begin
      credit_cnt <= credit_nxt;
      if (credit_sat) credit_ovf <= 1'b1;
      if (grant)      rr_pref    <= gnt0;
    end
  end

  // Layer FSM; op_en is only looked at in IDLE and RUN, so a re-raise
  // during DRAIN waits until the drain has finished.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      state <= IDLE;
      done  <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE:    if (op_en)  state <= RUN;
        RUN:     if (!op_en) state <= DRAIN;
        DRAIN: begin
          if (drain_fin) begin
            state <= IDLE;
            done  <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef CDP_RDMA_SCHED_PERF_EN
  logic [31:0] stall_q;

  // Count RUN cycles where something is requesting but nothing fits.
  always_ff @(posedge nvdla_core_clk) begin
    if (nvdla_core_rst) begin
      stall_q <= '0;
    end else if (state == IDLE && op_en) begin
      stall_q <= '0;
    end else if (state == RUN && (req0_valid || req1_valid) &&
                 !elig0 && !elig1 && stall_q != 32'hFFFF_FFFF) begin
      stall_q <= stall_q + 32'd1;
    end
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_cdp_rdma_rdreq_sched.sv
// Self-checking bench for cdp_rdma_rdreq_sched: directed scenarios plus a
// randomized phase, all checked each cycle against a transaction-level model.
module tb_cdp_rdma_rdreq_sched;

  localparam int D = 64;

  logic        clk = 1'b0;
  logic        rst;
  logic        op_en;
  logic        r0v, r1v;
  logic        r0rdy, r1rdy;
  logic [78:0] r0pd, r1pd;
  logic        dvld, drdy;
  logic [78:0] dpd;
  logic        dsrc;
  logic        pop;
  logic [6:0]  credit;
  logic        done, ovf;
  logic [31:0] stall;

  cdp_rdma_rdreq_sched #(.CDT_DEPTH(D), .CNT_W(7)) dut (
    .nvdla_core_clk(clk), .nvdla_core_rst(rst), .op_en(op_en),
    .req0_valid(r0v), .req0_ready(r0rdy), .req0_pd(r0pd),
    .req1_valid(r1v), .req1_ready(r1rdy), .req1_pd(r1pd),
    .dma_rd_req_valid(dvld), .dma_rd_req_ready(drdy),
    .dma_rd_req_pd(dpd), .dma_rd_req_src(dsrc),
    .cdt_lat_fifo_pop(pop), .credit_cnt(credit), .done(done),
    .credit_ovf(ovf), .stall_cnt(stall)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int n_done = 0;
  logic last_r0, last_r1;

  // Reference model: layer phase, credit pool, pending-output queue,
  // and which requester is owed the next tie.
  bit          m_init = 0;
  int          m_phase;   // 0 idle, 1 run, 2 drain
  int          m_credit;
  int          m_pref;
  bit          m_ovf, m_done;
  logic [31:0] m_stall;
  logic [79:0] m_q[$];    // {src, pd}

  task automatic chk(string tag, logic [78:0] obs, logic [78:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [78:0] mk(int sz);
    logic [63:0] a;
    a = {$urandom, $urandom};
    return {sz[14:0], a};
  endfunction

  // One clock: check outputs, advance the model, step to the next negedge.
  task automatic cyc();
    int c0, c1, w, cr;
    bit e0, e1;
    logic [31:0] exp_stall;
    #1;
    last_r0 = r0rdy;
    last_r1 = r1rdy;
    if (done === 1'b1) n_done++;
    if (m_init) begin
      chk("valid", 79'(dvld), 79'(m_q.size() > 0));
      if (m_q.size() > 0) begin
        chk("pd",  dpd, m_q[0][78:0]);
        chk("src", 79'(dsrc), 79'(m_q[0][79]));
      end
      chk("credit", 79'(credit), 79'(m_credit));
      chk("done",   79'(done),   79'(m_done));
      chk("ovf",    79'(ovf),    79'(m_ovf));
`ifdef CDP_RDMA_SCHED_PERF_EN
      exp_stall = m_stall;
`else
      exp_stall = 32'd0;
`endif
      chk("stall",  79'(stall),  79'(exp_stall));
    end
    if (rst) begin
      chk("rdy0_rst", 79'(r0rdy), 79'(0));
      chk("rdy1_rst", 79'(r1rdy), 79'(0));
      m_init = 1; m_phase = 0; m_credit = D; m_pref = 0;
      m_ovf = 0; m_done = 0; m_stall = 0; m_q.delete();
    end else if (m_init) begin
      c0 = int'(r0pd[78:64]) + 1;
      c1 = int'(r1pd[78:64]) + 1;
      e0 = r0v && (c0 <= m_credit);
      e1 = r1v && (c1 <= m_credit);
      w = -1;
      if (m_phase == 1 && (m_q.size() == 0 || drdy)) begin
        if (e0 && e1) w = m_pref;
        else if (e0)  w = 0;
        else if (e1)  w = 1;
      end
      chk("rdy0", 79'(r0rdy), 79'(w == 0));
      chk("rdy1", 79'(r1rdy), 79'(w == 1));
      if (m_phase == 1 && (r0v || r1v) && !e0 && !e1 && m_stall != 32'hFFFFFFFF)
        m_stall++;
      if (m_phase == 0 && op_en) m_stall = 0;
      if (m_q.size() > 0 && drdy) void'(m_q.pop_front());
      cr = m_credit + int'(pop);
      if (w == 0) begin m_q.push_back({1'b0, r0pd}); cr -= c0; m_pref = 1; end
      if (w == 1) begin m_q.push_back({1'b1, r1pd}); cr -= c1; m_pref = 0; end
      if (cr > D) begin cr = D; m_ovf = 1; end
      m_credit = cr;
      m_done = 0;
      case (m_phase)
        0: if (op_en)  m_phase = 1;
        1: if (!op_en) m_phase = 2;
        default: if (m_q.size() == 0 && m_credit == D) begin
          m_phase = 0; m_done = 1;
        end
      endcase
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic refill();
    r0v = 0; r1v = 0; drdy = 1;
    for (int i = 0; i < 200; i++) begin
      pop = (m_credit < D);
      cyc();
    end
    pop = 0;
    chk("refill_credit", 79'(credit), 79'(D));
  endtask

  initial begin
    logic [78:0] held;
    logic [6:0]  saved;
    bit got;
    rst = 1; op_en = 0; r0v = 0; r1v = 0; r0pd = '0; r1pd = '0;
    drdy = 1; pop = 0;
    @(negedge clk);
    cyc(); cyc();
    rst = 0;
    chk("rst_pd",  dpd, 79'(0));
    chk("rst_src", 79'(dsrc), 79'(0));
    chk("rst_credit", 79'(credit), 79'(D));

    // Single size-3 request from requester 0.
    op_en = 1; cyc();
    r0v = 1; r0pd = mk(3); cyc();
    r0v = 0;
    chk("single_rdy", 79'(last_r0), 79'(1));
    chk("single_vld", 79'(dvld), 79'(1));
    chk("single_credit", 79'(credit), 79'(60));
    cyc();

    // Both requesting continuously at size 0: alternate one per cycle.
    r0v = 1; r1v = 1; pop = 1;
    for (int i = 0; i < 6; i++) begin
      r0pd = mk(0); r1pd = mk(0);
      cyc();
      chk("alt_onehot", 79'(last_r0 ^ last_r1), 79'(1));
    end
    refill();

    // Low credits: small request passes the big one, big one waits for pops.
    r0v = 1; r0pd = mk(61); cyc();
    r0v = 0; cyc();
    chk("low_credit", 79'(credit), 79'(2));
    r0pd = mk(7); r1pd = mk(0); r0v = 1; r1v = 1;
    cyc();
    chk("bypass_r1", 79'(last_r1), 79'(1));
    chk("bypass_r0", 79'(last_r0), 79'(0));
    r1v = 0;
    cyc(); cyc();
    got = 0;
    pop = 1;
    for (int i = 0; i < 12 && !got; i++) begin
      cyc();
      if (last_r0) got = 1;
    end
    pop = 0;
    chk("big_granted", 79'(got), 79'(1));
    refill();

    // Downstream back-pressure holds the payload and blocks new grants.
    r0v = 1; r0pd = mk(0); drdy = 0; cyc();
    held = dpd;
    r0pd = mk(0);
    for (int i = 0; i < 5; i++) begin
      cyc();
      chk("bp_noready", 79'(last_r0), 79'(0));
      chk("bp_pd_hold", dpd, held);
    end
    drdy = 1; pop = 1; saved = credit;
    cyc();
    chk("net_credit", 79'(credit), 79'(saved));
    r0v = 0; pop = 0; cyc();

    // Randomized phase.
    for (int i = 0; i < 500; i++) begin
      if ($urandom_range(0, 99) < 3) op_en = ~op_en;
      r0v  = ($urandom_range(0, 1) == 1);
      r1v  = ($urandom_range(0, 1) == 1);
      r0pd = mk($urandom_range(0, 12));
      r1pd = mk($urandom_range(0, 12));
      drdy = ($urandom_range(0, 9) < 7);
      pop  = (m_credit < D) && ($urandom_range(0, 1) == 1);
      cyc();
    end

    // Drain with 10 atoms outstanding.
    op_en = 1; refill();
    r0v = 1; r0pd = mk(9); cyc();
    r0v = 0; op_en = 0;
    cyc(); cyc(); cyc();
    n_done = 0;
    pop = 1;
    for (int i = 0; i < 10; i++) cyc();
    pop = 0;
    chk("done_after_pops", 79'(done), 79'(1));
    cyc(); cyc(); cyc();
    chk("done_once", 79'(n_done), 79'(1));

    // Extra pop into a full pool.
    pop = 1; cyc();
    pop = 0; cyc();
    chk("ovf_set", 79'(ovf), 79'(1));
    chk("ovf_credit", 79'(credit), 79'(D));

    // Reset in the middle of a stalled transfer.
    op_en = 1; cyc();
    r0v = 1; r0pd = mk(4); drdy = 0; cyc(); cyc();
    rst = 1; cyc();
    rst = 0; r0v = 0; op_en = 0; drdy = 1;
    chk("rst_mid_vld", 79'(dvld), 79'(0));
    chk("rst_mid_credit", 79'(credit), 79'(D));
    chk("rst_mid_ovf", 79'(ovf), 79'(0));
    chk("rst_mid_done", 79'(done), 79'(0));
    cyc(); cyc();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
